complete_queue: RTL and testbench
=================================

COMPLETE_QUEUE -- requirements
Module: complete_queue

Interface
REQ-001 SHALL have parameter N, default `N, the ROB update lanes per cycle.
REQ-002 SHALL have parameter FU_COUNT, default `N+1, the functional-unit result ports.
REQ-003 SHALL have parameter CQ_DEPTH, default 8, the buffered results beyond the output register.
REQ-004 SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port fu_valid  input  FU_COUNT  per-FU result present.
REQ-007 SHALL have port fu_rob_idx  input  FU_COUNT x ROB_IDX  ROB slot of the result.
REQ-008 SHALL have port fu_value  input  FU_COUNT x DATA  result value.
REQ-009 SHALL have port fu_branch_taken  input  FU_COUNT  resolved direction (0 for non-branches).
REQ-010 SHALL have port fu_branch_target  input  FU_COUNT x ADDR  resolved target.
REQ-011 SHALL have port rob_mispredict  input  1  flush from retire.
REQ-012 SHALL have port fu_accept  output  FU_COUNT  combinational per-FU grant.
REQ-013 SHALL have port rob_update_packet  output  ROB_UPDATE_PACKET  registered N-lane completion to the ROB.
REQ-014 SHALL have port cq_count  output  $clog2(CQ_DEPTH+1)  registered occupancy.

Function
REQ-015 SHALL compute free = CQ_DEPTH - cq_count from registered state only, with no credit for same-cycle drain.
REQ-016 SHALL set fu_accept[i]=1 iff fu_valid[i], rob_mispredict=0, reset=0, and fewer than free+N lower-index FUs are accepted; otherwise fu_accept[i]=0.
REQ-017 SHALL order results as a stream: queued entries oldest-first, then accepted FU results in ascending FU index.
REQ-018 SHALL load the first min(N, stream length) stream entries into rob_update_packet lanes 0 upward at each edge, setting valid, idx, values, branch_taken and branch_targets per lane.
REQ-019 SHALL drive unused lanes with valid=0 and all other lane fields zero.
REQ-020 SHALL write the remaining stream entries into the circular queue in order and update cq_count = old count - drained + enqueued.
REQ-021 SHALL give latency 1: a result accepted before edge t with an empty queue SHALL be visible on rob_update_packet after edge t.
REQ-022 SHALL hold rob_update_packet valid for exactly one cycle per entry, with no duplication and no loss of any accepted result.
REQ-023 SHALL wrap head/tail pointers modulo CQ_DEPTH, support non-power-of-two depth, and never exceed cq_count = CQ_DEPTH.
REQ-024 SHALL, on rob_mispredict=1 at an edge, empty the queue (cq_count=0, pointers equal), clear all rob_update_packet valid bits, and drop same-cycle FU inputs; this flush SHALL take precedence over drain and enqueue.
REQ-025 SHALL NOT alter ROB indices or values; fu_rob_idx SHALL be passed through.
REQ-026 SHALL accept results in any ROB order, since ROB completion is order-independent.

Reset
REQ-027 SHALL, on reset=1 at an edge, set cq_count=0, head=tail=0 and rob_update_packet all zero.
REQ-028 SHALL drive fu_accept=0 while reset=1, and reset mid-operation SHALL discard all queued results identically to a flush.

Verification (N=2, FU_COUNT=3, CQ_DEPTH=4)
REQ-029 SHALL cover single result: FU0 idx 10 value 0x55 with empty queue -> accept=001, next cycle lane0 valid idx 10 value 0x55, lane1 invalid, cq_count 0.
REQ-030 SHALL cover overflow into the queue: FU0/1/2 idx 3/4/5 all valid -> accept=111; next cycle lanes {3,4}, cq_count 1; following cycle lane0 idx 5, cq_count 0.
REQ-031 SHALL cover backpressure: all three FUs valid for 4 consecutive cycles -> cq_count reaches 4, then accept=011 (free 0, N=2 pass-through); no result lost or reordered, with the scoreboard matching output order.
REQ-032 SHALL cover branch completion: FU1 idx 20 taken=1 target 0x100 -> next cycle lane0 idx 20, branch_taken 1, branch_targets 0x100.
REQ-033 SHALL cover flush: cq_count 3 with rob_mispredict=1 plus FU0 valid -> accept=000; next cycle cq_count 0 and all lanes invalid; new results after flush complete with latency 1.
REQ-034 SHALL cover wrap-around: 10 cycles of 3 results each with alternating flush-free drains -> pointers wrap past 3 and the output sequence equals the input sequence.

Source files
------------

// File: rtl/complete_queue.sv
// Completion queue: merges functional-unit results into a registered N-lane ROB update
// packet. Results that do not fit in this cycle's lanes wait in a circular buffer.
`ifndef N
`define N 2
`endif

module complete_queue #(
  parameter int N         = `N,
  parameter int FU_COUNT  = `N + 1,
  parameter int CQ_DEPTH  = 8,
  parameter int ROB_IDX_W = 6,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  // Packet lane layout, lane 0 at the LSBs: {valid, idx, value, branch_taken, branch_target}
  localparam int LANE_W   = 2 + ROB_IDX_W + DATA_W + ADDR_W,
  localparam int CNT_W    = $clog2(CQ_DEPTH + 1)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [FU_COUNT-1:0]                fu_valid,
  input  logic [FU_COUNT-1:0][ROB_IDX_W-1:0] fu_rob_idx,
  input  logic [FU_COUNT-1:0][DATA_W-1:0]    fu_value,
  input  logic [FU_COUNT-1:0]                fu_branch_taken,
  input  logic [FU_COUNT-1:0][ADDR_W-1:0]    fu_branch_target,
  input  logic                               rob_mispredict,
  output logic [FU_COUNT-1:0]                fu_accept,
  output logic [N*LANE_W-1:0]                rob_update_packet,
  output logic [CNT_W-1:0]                   cq_count
);

  localparam int PTR_W = (CQ_DEPTH > 1) ? $clog2(CQ_DEPTH) : 1;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    value;
    logic                 taken;
    logic [ADDR_W-1:0]    target;
  } entry_t;

  typedef struct packed {
    logic   valid;
    entry_t e;
  } lane_t;

  entry_t             mem [CQ_DEPTH];
  logic [PTR_W-1:0]   head, tail;
  lane_t [N-1:0]      lanes_q;

  entry_t             fu_entry [FU_COUNT];
  int                 fu_rank  [FU_COUNT];
  logic               enq_en   [FU_COUNT];
  logic [PTR_W-1:0]   enq_ptr  [FU_COUNT];
  int                 n_accept, q_drain, n_out, fu_direct;
  lane_t [N-1:0]      lanes_d;
  logic [PTR_W-1:0]   head_d, tail_d;
  logic [CNT_W-1:0]   count_d;

  assign rob_update_packet = lanes_q;

  // Pointer arithmetic is done in int and folded back, so any depth works.
  function automatic logic [PTR_W-1:0] wrap(input int v);
    return PTR_W'(v % CQ_DEPTH);
  endfunction

  always_comb begin
    for (int i = 0; i < FU_COUNT; i++) begin
      fu_entry[i].idx    = fu_rob_idx[i];
      fu_entry[i].value  = fu_value[i];
      fu_entry[i].taken  = fu_branch_taken[i];
      fu_entry[i].target = fu_branch_target[i];
    end
  end

  always_comb begin
    int granted;
    int cnt;
    // NOTE: every combinational output is given a default first so no path can infer a latch.
    cnt       = int'(cq_count);
    granted   = 0;
    fu_accept = '0;
    lanes_d   = '0;

    // Grant budget uses only registered occupancy: free slots plus the N output lanes.
    for (int i = 0; i < FU_COUNT; i++) begin
      fu_rank[i] = granted;
      if (fu_valid[i] && !rob_mispredict && !reset && (granted < CQ_DEPTH - cnt + N)) begin
        fu_accept[i] = 1'b1;
        granted      = granted + 1;
      end
    end
    n_accept  = granted;

    q_drain   = (cnt < N) ? cnt : N;
    n_out     = (cnt + n_accept < N) ? (cnt + n_accept) : N;
    fu_direct = n_out - q_drain;

    // Stream order: queued entries oldest-first, then granted FUs by ascending index.
    for (int l = 0; l < N; l++) begin
      if (l < q_drain) begin
        lanes_d[l].valid = 1'b1;
        lanes_d[l].e     = mem[wrap(int'(head) + l)];
      end else if (l < n_out) begin
        for (int i = 0; i < FU_COUNT; i++) begin
          if (fu_accept[i] && (fu_rank[i] == l - q_drain)) begin
            lanes_d[l].valid = 1'b1;
            lanes_d[l].e     = fu_entry[i];
          end
        end
      end
    end

    for (int i = 0; i < FU_COUNT; i++) begin
      enq_en[i]  = fu_accept[i] && (fu_rank[i] >= fu_direct);
      enq_ptr[i] = enq_en[i] ? wrap(int'(tail) + fu_rank[i] - fu_direct) : '0;
    end

    head_d  = wrap(int'(head) + q_drain);
    tail_d  = wrap(int'(tail) + n_accept - fu_direct);
    count_d = CNT_W'(cnt - q_drain + n_accept - fu_direct);
  end

  // Flush and reset share one path: both discard everything buffered or in flight.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset || rob_mispredict) begin
      head     <= '0;
      tail     <= '0;
      cq_count <= '0;
      lanes_q  <= '0;
    end else begin
      head     <= head_d;
      tail     <= tail_d;
      cq_count <= count_d;
      lanes_q  <= lanes_d;
    end
  end

  // NOTE: the entry storage has no reset; occupancy and pointers alone decide what is live.
  always_ff @(posedge clock) begin
    for (int i = 0; i < FU_COUNT; i++) begin
      if (enq_en[i]) mem[enq_ptr[i]] <= fu_entry[i];
    end
  end

endmodule

// File: tb/tb_complete_queue.sv
// Scoreboard bench for complete_queue (N=2, FU_COUNT=3, CQ_DEPTH=4): the driver pushes
// granted results, a negedge monitor pops them as packet lanes appear.
module tb_complete_queue;
  localparam int N         = 2;
  localparam int FU_COUNT  = 3;
  localparam int CQ_DEPTH  = 4;
  localparam int ROB_IDX_W = 6;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int LANE_W    = 2 + ROB_IDX_W + DATA_W + ADDR_W;
  localparam int CNT_W     = $clog2(CQ_DEPTH + 1);

  typedef struct packed {
    logic [ROB_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    value;
    logic                 taken;
    logic [ADDR_W-1:0]    target;
  } entry_t;

  typedef struct packed {
    logic   valid;
    entry_t e;
  } lane_t;

  logic                               clock = 1'b0;
  logic                               reset;
  logic [FU_COUNT-1:0]                fu_valid;
  logic [FU_COUNT-1:0][ROB_IDX_W-1:0] fu_rob_idx;
  logic [FU_COUNT-1:0][DATA_W-1:0]    fu_value;
  logic [FU_COUNT-1:0]                fu_branch_taken;
  logic [FU_COUNT-1:0][ADDR_W-1:0]    fu_branch_target;
  logic                               rob_mispredict;
  logic [FU_COUNT-1:0]                fu_accept;
  logic [N*LANE_W-1:0]                pkt_flat;
  logic [CNT_W-1:0]                   cq_count;
  lane_t [N-1:0]                      pkt;

  assign pkt = pkt_flat;

  complete_queue #(
    .N(N), .FU_COUNT(FU_COUNT), .CQ_DEPTH(CQ_DEPTH),
    .ROB_IDX_W(ROB_IDX_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fu_valid(fu_valid),
    .fu_rob_idx(fu_rob_idx),
    .fu_value(fu_value),
    .fu_branch_taken(fu_branch_taken),
    .fu_branch_target(fu_branch_target),
    .rob_mispredict(rob_mispredict),
    .fu_accept(fu_accept),
    .rob_update_packet(pkt_flat),
    .cq_count(cq_count)
  );

  always #5 clock = ~clock;

  int     checks = 0;
  int     errors = 0;
  entry_t exp_q[$];
  int     model_count = 0;
  int     exp_nv = 0;
  entry_t stim [FU_COUNT];
  bit     mon_en = 1'b0;
  string  last_tag = "reset";

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int nvalid();
    int n = 0;
    for (int l = 0; l < N; l++) if (pkt[l].valid === 1'b1) n++;
    return n;
  endfunction

  // Monitor: every valid lane must be the oldest outstanding result.
  always @(negedge clock) begin
    if (mon_en) begin
      for (int l = 0; l < N; l++) begin
        if (pkt[l].valid === 1'b1) begin
          if (l > 0) check($sformatf("lane%0d contiguous", l), pkt[l-1].valid, 1'b1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL lane%0d spurious result idx %0d, nothing outstanding", l, pkt[l].e.idx);
          end else begin
            entry_t e;
            e = exp_q.pop_front();
            check($sformatf("lane%0d entry idx %0d", l, e.idx), pkt[l].e, e);
          end
        end else begin
          check($sformatf("lane%0d idle fields", l), pkt[l], '0);
        end
      end
    end
  end

  function automatic entry_t mk(input int idx, input int val, input bit tk, input int tg);
    entry_t e;
    e.idx    = ROB_IDX_W'(idx);
    e.value  = DATA_W'(val);
    e.taken  = tk;
    e.target = ADDR_W'(tg);
    return e;
  endfunction

  // One cycle: check the outcome of the previous edge, drive, check grants, update the model.
  task automatic step(input logic [2:0] v, input logic fl, input logic rs,
                      input logic [2:0] exp_acc, input string tag);
    int len;
    int nacc;
    @(negedge clock);
    #1;
    check({"after ", last_tag, " cq_count"}, cq_count, model_count);
    check({"after ", last_tag, " valid lanes"}, nvalid(), exp_nv);
    fu_valid       = v;
    rob_mispredict = fl;
    reset          = rs;
    for (int i = 0; i < FU_COUNT; i++) begin
      fu_rob_idx[i]       = stim[i].idx;
      fu_value[i]         = stim[i].value;
      fu_branch_taken[i]  = stim[i].taken;
      fu_branch_target[i] = stim[i].target;
    end
    #1;
    check({tag, " fu_accept"}, fu_accept, exp_acc);
    if (fl || rs) begin
      exp_q.delete();
      model_count = 0;
      exp_nv      = 0;
    end else begin
      nacc = 0;
      for (int i = 0; i < FU_COUNT; i++) begin
        if (exp_acc[i]) begin
          exp_q.push_back(stim[i]);
          nacc++;
        end
      end
      len         = model_count + nacc;
      exp_nv      = (len < N) ? len : N;
      model_count = len - exp_nv;
    end
    last_tag = tag;
  endtask

  task automatic idle(input string tag);
    step(3'b000, 1'b0, 1'b0, 3'b000, tag);
  endtask

  task automatic load3(input int base, input int val);
    for (int i = 0; i < FU_COUNT; i++) stim[i] = mk(base + i, val + i, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    load3(60, 32'h77);
    reset = 1'b1;
    rob_mispredict = 1'b0;
    fu_valid = 3'b111;
    fu_rob_idx = '0; fu_value = '0; fu_branch_taken = '0; fu_branch_target = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset fu_accept", fu_accept, 3'b000);
    check("reset cq_count", cq_count, 0);
    for (int l = 0; l < N; l++) check($sformatf("reset lane%0d", l), pkt[l], '0);
    mon_en = 1'b1;

    // Single result, latency 1.
    stim[0] = mk(10, 32'h55, 1'b0, 0);
    step(3'b001, 1'b0, 1'b0, 3'b001, "single");
    idle("idle1");

    // Three results, two lanes: one spills into the queue.
    load3(3, 32'h33);
    step(3'b111, 1'b0, 1'b0, 3'b111, "overflow");
    idle("overflow drain1");
    idle("overflow drain2");

    // Backpressure: queue fills to 4, then only N pass-through grants remain.
    load3(30, 32'h300); step(3'b111, 1'b0, 1'b0, 3'b111, "bp1");
    load3(33, 32'h330); step(3'b111, 1'b0, 1'b0, 3'b111, "bp2");
    load3(36, 32'h360); step(3'b111, 1'b0, 1'b0, 3'b111, "bp3");
    load3(39, 32'h390); step(3'b111, 1'b0, 1'b0, 3'b111, "bp4");
    load3(42, 32'h420); step(3'b111, 1'b0, 1'b0, 3'b011, "bp full");
    load3(45, 32'h450); step(3'b101, 1'b0, 1'b0, 3'b101, "bp sparse");
    for (int k = 0; k < 3; k++) idle("bp drain");

    // Branch completion.
    stim[1] = mk(20, 32'hdead, 1'b1, 32'h100);
    step(3'b010, 1'b0, 1'b0, 3'b010, "branch");
    idle("branch drain");

    // Flush with three queued entries and a same-cycle FU result.
    load3(1, 32'h1000); step(3'b111, 1'b0, 1'b0, 3'b111, "pre-flush1");
    load3(4, 32'h1100); step(3'b111, 1'b0, 1'b0, 3'b111, "pre-flush2");
    load3(7, 32'h1200); step(3'b111, 1'b0, 1'b0, 3'b111, "pre-flush3");
    stim[0] = mk(11, 32'hbad, 1'b0, 0);
    step(3'b001, 1'b1, 1'b0, 3'b000, "flush");
    stim[2] = mk(12, 32'h600d, 1'b0, 0);
    step(3'b100, 1'b0, 1'b0, 3'b100, "post-flush");
    idle("post-flush drain");

    // Wrap-around: pointers advance one slot per burst; occupancy never exceeds 1.
    for (int k = 0; k < 10; k++) begin
      load3(k * 3, 32'h2000 + k * 16);
      step(3'b111, 1'b0, 1'b0, 3'b111, $sformatf("wrap%0d", k));
      idle($sformatf("wrap%0d drain", k));
    end

    // Reset in mid-operation behaves like a flush.
    load3(50, 32'h500); step(3'b111, 1'b0, 1'b0, 3'b111, "pre-reset1");
    load3(53, 32'h530); step(3'b111, 1'b0, 1'b0, 3'b111, "pre-reset2");
    load3(56, 32'h560); step(3'b111, 1'b1 & 1'b0, 1'b1, 3'b000, "mid reset");
    load3(13, 32'h700); step(3'b011, 1'b0, 1'b0, 3'b011, "post-reset");

    for (int k = 0; k < 4 && exp_q.size() != 0; k++) idle("final drain");
    idle("final");
    idle("final settle");
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL lost results: %0d still outstanding, required 0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
